// File: rtl/s27_response_monitor.sv
// Response-capture stage for the s27 core: compacts G17 into a serial signature
// over a programmable window, counts ones/toggles and checks against a golden value.
module s27_response_monitor #(
    parameter int unsigned      SIG_W = 16,
    parameter logic [SIG_W-1:0] POLY  = 16'h8005,
    parameter logic [SIG_W-1:0] SEED  = 16'hFFFF,
    parameter int unsigned      CNT_W = 10,
    parameter int unsigned      SKIP  = 2
) (
    input  logic             CK,
    input  logic             reset,
    input  logic             G17,
    input  logic             start,
    input  logic [CNT_W-1:0] win_len,
    input  logic [SIG_W-1:0] expected_sig,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic [SIG_W-1:0] signature,
    output logic [CNT_W-1:0] ones_count,
    output logic [CNT_W-1:0] toggle_count
);

    localparam int unsigned SKIP_W = (SKIP > 32'd1) ? $clog2(SKIP + 32'd1) : 32'd1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SKIP    = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    state_t             entry_s;
    logic               accept_s;
    logic               match_s;
    logic [1:0]         rst_sync_r;
    logic [SKIP_W-1:0]  skip_cnt_r;
    logic [CNT_W-1:0]   remain_r;
    logic [SIG_W-1:0]   exp_sig_r;
    logic [SIG_W-1:0]   signature_r;
    logic [CNT_W-1:0]   ones_r;
    logic [CNT_W-1:0]   toggles_r;
    logic               prev_r;
    logic               first_r;
    logic               busy_r;
    logic               done_r;
    logic               pass_r;
    logic               fail_r;

    // One serial-signature step: shift left, fold in POLY when feedback is set.
    function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0] sig, input logic din);
        logic fb;
        fb = sig[SIG_W-1] ^ din;
        return {sig[SIG_W-2:0], 1'b0} ^ (fb ? POLY : {SIG_W{1'b0}});
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val, input logic inc);
        logic [CNT_W-1:0] res;
        if (inc && (val != {CNT_W{1'b1}})) begin
            res = val + CNT_W'(1);
        end else begin
            res = val;
        end
        return res;
    endfunction

    assign match_s = (signature_r == exp_sig_r);

    // Reset release synchroniser; the FSM may only leave IDLE/DONE once it reads high.
    always_ff @(posedge CK or negedge reset) begin
        if (!reset) begin
            rst_sync_r <= 2'b00;
        end else begin
            rst_sync_r <= {rst_sync_r[0], 1'b1};
        end
    end

    // State register.
    always_ff @(posedge CK or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic and start acceptance.
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        entry_s     = ST_DONE;
        if (SKIP != 32'd0) begin
            entry_s = ST_SKIP;
        end else if (win_len != {CNT_W{1'b0}}) begin
            entry_s = ST_CAPTURE;
        end else begin
            entry_s = ST_DONE;
        end
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start && rst_sync_r[1]) begin
                    accept_s    = 1'b1;
                    state_nxt_s = entry_s;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_SKIP: begin
                if (skip_cnt_r == SKIP_W'(1)) begin
                    state_nxt_s = (remain_r == {CNT_W{1'b0}}) ? ST_DONE : ST_CAPTURE;
                end else begin
                    state_nxt_s = ST_SKIP;
                end
            end
            ST_CAPTURE: begin
                if (remain_r == CNT_W'(1)) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_CAPTURE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Capture datapath: signature, counters, and the verdict one cycle after the last sample.
    always_ff @(posedge CK or negedge reset) begin
        if (!reset) begin
            skip_cnt_r  <= {SKIP_W{1'b0}};
            remain_r    <= {CNT_W{1'b0}};
            exp_sig_r   <= {SIG_W{1'b0}};
            signature_r <= SEED;
            ones_r      <= {CNT_W{1'b0}};
            toggles_r   <= {CNT_W{1'b0}};
            prev_r      <= 1'b0;
            first_r     <= 1'b1;
            done_r      <= 1'b0;
            pass_r      <= 1'b0;
            fail_r      <= 1'b0;
        end else if (accept_s) begin
            skip_cnt_r  <= SKIP_W'(SKIP);
            remain_r    <= win_len;
            exp_sig_r   <= expected_sig;
            signature_r <= SEED;
            ones_r      <= {CNT_W{1'b0}};
            toggles_r   <= {CNT_W{1'b0}};
            prev_r      <= 1'b0;
            first_r     <= 1'b1;
            done_r      <= 1'b0;
            pass_r      <= 1'b0;
            fail_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_SKIP: begin
                    skip_cnt_r <= skip_cnt_r - SKIP_W'(1);
                end
                ST_CAPTURE: begin
                    signature_r <= misr_step(signature_r, G17);
                    ones_r      <= sat_inc(ones_r, G17);
                    toggles_r   <= sat_inc(toggles_r, !first_r && (G17 != prev_r));
                    prev_r      <= G17;
                    first_r     <= 1'b0;
                    remain_r    <= remain_r - CNT_W'(1);
                end
                ST_DONE: begin
                    if (!done_r) begin
                        done_r <= 1'b1;
                        pass_r <= match_s;
                        fail_r <= !match_s;
                    end
                end
                default: begin
                    done_r <= 1'b0;
                end
            endcase
        end
    end

    // Busy flag registered from the next state so it rises right after the accepting edge.
    always_ff @(posedge CK or negedge reset) begin
        if (!reset) begin
            busy_r <= 1'b0;
        end else begin
            busy_r <= (state_nxt_s == ST_SKIP) || (state_nxt_s == ST_CAPTURE);
        end
    end

    assign busy         = busy_r;
    assign done         = done_r;
    assign pass         = pass_r;
    assign fail         = fail_r;
    assign signature    = signature_r;
    assign ones_count   = ones_r;
    assign toggle_count = toggles_r;

endmodule

// File: tb/tb_s27_response_monitor.sv
// Directed bench for s27_response_monitor: hand-computed signatures, counts and latencies.
module tb_s27_response_monitor;

    logic        CK = 1'b0;
    logic        reset = 1'b0;
    logic        G17 = 1'b0;
    logic        start = 1'b0;
    logic [9:0]  win_len = 10'd0;
    logic [15:0] expected_sig = 16'h0000;
    logic        busy, done, pass, fail;
    logic [15:0] signature;
    logic [9:0]  ones_count, toggle_count;

    logic        G17_b = 1'b0;
    logic        start_b = 1'b0;
    logic [2:0]  win_len_b = 3'd0;
    logic [15:0] expected_sig_b = 16'h0000;
    logic        busy_b, done_b, pass_b, fail_b;
    logic [15:0] signature_b;
    logic [2:0]  ones_count_b, toggle_count_b;

    int checks = 0;
    int failures = 0;

    always #5 CK = ~CK;

    s27_response_monitor dut (
        .CK(CK), .reset(reset), .G17(G17), .start(start), .win_len(win_len),
        .expected_sig(expected_sig), .busy(busy), .done(done), .pass(pass), .fail(fail),
        .signature(signature), .ones_count(ones_count), .toggle_count(toggle_count)
    );

    s27_response_monitor #(.CNT_W(3)) dut_b (
        .CK(CK), .reset(reset), .G17(G17_b), .start(start_b), .win_len(win_len_b),
        .expected_sig(expected_sig_b), .busy(busy_b), .done(done_b), .pass(pass_b), .fail(fail_b),
        .signature(signature_b), .ones_count(ones_count_b), .toggle_count(toggle_count_b)
    );

    // Start pulse accepted at edge T0; inputs are scrambled afterwards to prove latching.
    task automatic do_start(input logic [9:0] wl, input logic [15:0] es);
        @(posedge CK); #1;
        start = 1'b1; win_len = wl; expected_sig = es;
        @(posedge CK); #1;
        start = 1'b0; win_len = ~wl; expected_sig = ~es;
    endtask

    // Drives SKIP junk then pat[0..wl-1]; returns just after edge T0+2+wl.
    task automatic run_window(input logic [9:0] wl, input logic [15:0] es, input logic [15:0] pat,
                              output logic busy_seen);
        do_start(wl, es);
        busy_seen = busy;
        for (int c = 1; c <= 2 + int'(wl); c++) begin
            G17 = (c > 2) ? pat[c - 3] : ~pat[0];
            @(posedge CK); #1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge CK);
        #1;
        checks++; if (signature !== 16'hFFFF) begin failures++; $display("FAIL reset_sig got=%h exp=%h", signature, 16'hFFFF); end
        checks++; if ({busy, done, pass, fail} !== 4'b0000) begin failures++; $display("FAIL reset_flags got=%b exp=0000", {busy, done, pass, fail}); end
        checks++; if (ones_count !== 10'd0 || toggle_count !== 10'd0) begin failures++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", ones_count, toggle_count); end
        reset = 1'b1;
        repeat (5) @(posedge CK);
        #1;
        checks++; if (signature !== 16'hFFFF || {busy, done, pass, fail} !== 4'b0000) begin
            failures++; $display("FAIL idle_stable got=%h/%b exp=ffff/0000", signature, {busy, done, pass, fail});
        end
    endtask

    task automatic test_const_zero();
        logic bs;
        run_window(10'd4, 16'hFFD2, 16'h0000, bs);
        checks++; if (bs !== 1'b1) begin failures++; $display("FAIL zero_busy got=%b exp=1", bs); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL zero_done_early got=%b exp=0", done); end
        @(posedge CK); #1;
        checks++; if (done !== 1'b1 || pass !== 1'b1 || fail !== 1'b0) begin failures++; $display("FAIL zero_verdict got=%b%b%b exp=110", done, pass, fail); end
        checks++; if (signature !== 16'hFFD2) begin failures++; $display("FAIL zero_sig got=%h exp=ffd2", signature); end
        checks++; if (ones_count !== 10'd0 || toggle_count !== 10'd0) begin failures++; $display("FAIL zero_cnt got=%0d/%0d exp=0/0", ones_count, toggle_count); end
    endtask

    task automatic test_const_one();
        logic bs;
        run_window(10'd4, 16'hFFF0, 16'h000F, bs);
        @(posedge CK); #1;
        checks++; if (done !== 1'b1 || pass !== 1'b1 || fail !== 1'b0) begin failures++; $display("FAIL one_verdict got=%b%b%b exp=110", done, pass, fail); end
        checks++; if (signature !== 16'hFFF0) begin failures++; $display("FAIL one_sig got=%h exp=fff0", signature); end
        checks++; if (ones_count !== 10'd4 || toggle_count !== 10'd0) begin failures++; $display("FAIL one_cnt got=%0d/%0d exp=4/0", ones_count, toggle_count); end
        run_window(10'd4, 16'hFFD2, 16'h000F, bs);
        @(posedge CK); #1;
        checks++; if (done !== 1'b1 || pass !== 1'b0 || fail !== 1'b1) begin failures++; $display("FAIL one_fail_verdict got=%b%b%b exp=101", done, pass, fail); end
    endtask

    task automatic test_alternating();
        logic bs;
        run_window(10'd4, 16'hFFEE, 16'h0005, bs);
        @(posedge CK); #1;
        checks++; if (signature !== 16'hFFEE || pass !== 1'b1) begin failures++; $display("FAIL alt_sig got=%h/%b exp=ffee/1", signature, pass); end
        checks++; if (ones_count !== 10'd2 || toggle_count !== 10'd3) begin failures++; $display("FAIL alt_cnt got=%0d/%0d exp=2/3", ones_count, toggle_count); end
        run_window(10'd4, 16'hFFEE, 16'h0007, bs);
        @(posedge CK); #1;
        checks++; if (signature !== 16'h7FF5 || fail !== 1'b1) begin failures++; $display("FAIL alt_flip_sig got=%h/%b exp=7ff5/1", signature, fail); end
        checks++; if (ones_count !== 10'd3 || toggle_count !== 10'd1) begin failures++; $display("FAIL alt_flip_cnt got=%0d/%0d exp=3/1", ones_count, toggle_count); end
    endtask

    task automatic test_boundary();
        logic bs;
        run_window(10'd0, 16'hFFFF, 16'h0000, bs);
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL wl0_done_early got=%b exp=0", done); end
        @(posedge CK); #1;
        checks++; if (done !== 1'b1 || pass !== 1'b1 || signature !== 16'hFFFF) begin
            failures++; $display("FAIL wl0_verdict got=%b%b/%h exp=11/ffff", done, pass, signature);
        end
        do_start(10'd4, 16'hFFD2);
        for (int c = 1; c <= 6; c++) begin
            G17 = (c > 2) ? 1'b0 : 1'b1;
            start = (c == 4) ? 1'b1 : 1'b0;
            win_len = 10'd1;
            @(posedge CK); #1;
        end
        start = 1'b0;
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL pulse_done_early got=%b exp=0", done); end
        @(posedge CK); #1;
        checks++; if (done !== 1'b1 || pass !== 1'b1 || signature !== 16'hFFD2) begin
            failures++; $display("FAIL pulse_ignored got=%b%b/%h exp=11/ffd2", done, pass, signature);
        end
    endtask

    task automatic test_saturation();
        for (int r = 0; r < 2; r++) begin
            @(posedge CK); #1;
            start_b = 1'b1; win_len_b = 3'd7; expected_sig_b = 16'hFF80; G17_b = 1'b1;
            @(posedge CK); #1;
            start_b = 1'b0; win_len_b = 3'd0;
            repeat (10) @(posedge CK);
            #1;
            checks++; if (done_b !== 1'b1 || pass_b !== 1'b1 || signature_b !== 16'hFF80) begin
                failures++; $display("FAIL sat_verdict run=%0d got=%b%b/%h exp=11/ff80", r, done_b, pass_b, signature_b);
            end
            checks++; if (ones_count_b !== 3'd7 || toggle_count_b !== 3'd0) begin
                failures++; $display("FAIL sat_cnt run=%0d got=%0d/%0d exp=7/0", r, ones_count_b, toggle_count_b);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic bs;
        do_start(10'd4, 16'hFFF0);
        G17 = 1'b1;
        repeat (3) @(posedge CK);
        #1;
        reset = 1'b0;
        #1;
        checks++; if ({busy, done, pass, fail} !== 4'b0000 || signature !== 16'hFFFF || ones_count !== 10'd0) begin
            failures++; $display("FAIL midreset got=%b/%h/%0d exp=0000/ffff/0", {busy, done, pass, fail}, signature, ones_count);
        end
        @(posedge CK); #1;
        reset = 1'b1;
        repeat (3) @(posedge CK);
        #1;
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL midreset_idle got=%b%b exp=00", busy, done); end
        run_window(10'd4, 16'hFFF0, 16'h000F, bs);
        @(posedge CK); #1;
        checks++; if (done !== 1'b1 || pass !== 1'b1 || signature !== 16'hFFF0 || ones_count !== 10'd4) begin
            failures++; $display("FAIL after_reset_run got=%b%b/%h/%0d exp=11/fff0/4", done, pass, signature, ones_count);
        end
    endtask

    initial begin
        test_reset();
        repeat (2) @(posedge CK);
        test_const_zero();
        test_const_one();
        test_alternating();
        test_boundary();
        test_saturation();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
